// File: rtl/fp_special_classify_pipe_if.sv
// Operand/result handshake bundle for the FP special-case classifier.
// master drives operands and out_ready; slave is the classifier.
interface fp_special_classify_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic             mode_sqrt;
    logic             sign_in;
    logic [EXP_W-1:0] exp_in;
    logic [MAN_W-1:0] mant_in;
    logic             out_valid;
    logic             out_ready;
    logic             sign_out;
    logic [EXP_W-1:0] exp_out;
    logic [MAN_W-1:0] mant_out;
    logic             is_nan;
    logic             is_snan;
    logic             is_pinf;
    logic             is_ninf;
    logic             is_zero;
    logic             is_subnormal;
    logic             is_normal;
    logic             bypass;
    logic             invalid;

    modport master (
        output in_valid, mode_sqrt, sign_in, exp_in, mant_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, mant_out,
        input  is_nan, is_snan, is_pinf, is_ninf, is_zero,
        input  is_subnormal, is_normal, bypass, invalid
    );

    modport slave (
        input  in_valid, mode_sqrt, sign_in, exp_in, mant_in, out_ready,
        output in_ready, out_valid, sign_out, exp_out, mant_out,
        output is_nan, is_snan, is_pinf, is_ninf, is_zero,
        output is_subnormal, is_normal, bypass, invalid
    );
endinterface

// File: rtl/fp_special_classify_pipe.sv
// Special-operand classifier with IEEE special-case result and bypass flag.
// Results pass through a 2-entry buffer; invalid deliveries are counted.
module fp_special_classify_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int FTZ   = 0,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    fp_special_classify_pipe_if.slave   bus,
    output logic [CNT_W-1:0]            invalid_cnt
);
    localparam logic [MAN_W-1:0] QBIT = {1'b1, {(MAN_W-1){1'b0}}};
    localparam bit FTZ_ON = (FTZ != 0);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
        logic             is_nan;
        logic             is_snan;
        logic             is_pinf;
        logic             is_ninf;
        logic             is_zero;
        logic             is_subnormal;
        logic             is_normal;
        logic             bypass;
        logic             invalid;
    } rec_t;

    rec_t             res;
    rec_t             head;
    rec_t             spare;
    logic [1:0]       count;
    logic [1:0]       count_nx;
    logic             held_valid;
    logic             ready;
    logic [CNT_W-1:0] inv_count;
    logic             accept;
    logic             deliver;

    logic emax_hit, exp_zero, man_zero;
    logic nan_c, inf_c, zero_c, sub_c, neg_bad;

    assign accept  = bus.in_valid & ready & enable;
    assign deliver = held_valid & bus.out_ready & enable;

    // Decode operand classes and build the special-case result record
    always_comb begin
        emax_hit = &bus.exp_in;
        exp_zero = ~|bus.exp_in;
        man_zero = ~|bus.mant_in;
        nan_c    = emax_hit & ~man_zero;
        inf_c    = emax_hit & man_zero;
        sub_c    = exp_zero & ~man_zero;
        zero_c   = exp_zero & (man_zero | FTZ_ON);
        neg_bad  = bus.mode_sqrt & bus.sign_in & ~nan_c & ~zero_c;
        res      = '0;
        res.sign = bus.sign_in;
        res.exp  = bus.exp_in;
        res.mant = bus.mant_in;
        if (nan_c) begin
            res.mant    = bus.mant_in | QBIT;
            res.is_nan  = 1'b1;
            res.is_snan = ~bus.mant_in[MAN_W-1];
            res.invalid = ~bus.mant_in[MAN_W-1];
        end else if (neg_bad) begin
            res.sign    = 1'b1;
            res.exp     = '1;
            res.mant    = QBIT;
            res.is_nan  = 1'b1;
            res.invalid = 1'b1;
        end else if (inf_c) begin
            res.is_pinf = ~bus.sign_in;
            res.is_ninf = bus.sign_in;
        end else if (zero_c) begin
            res.exp     = '0;
            res.mant    = '0;
            res.is_zero = 1'b1;
        end else if (sub_c) begin
            res.is_subnormal = 1'b1;
        end else begin
            res.is_normal = 1'b1;
        end
        res.bypass = res.is_nan | res.is_pinf | res.is_ninf | res.is_zero;
    end

    // Occupancy after this cycle's accept/deliver
    always_comb begin
        count_nx = count;
        if (accept & ~deliver) count_nx = count + 2'd1;
        else if (deliver & ~accept) count_nx = count - 2'd1;
    end

    // Head register feeds out_*; spare holds the second entry when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            spare      <= '0;
            count      <= '0;
            held_valid <= 1'b0;
            ready      <= 1'b0;
            inv_count  <= '0;
        end else if (!enable) begin
            count      <= '0;
            held_valid <= 1'b0;
            ready      <= 1'b0;
        end else begin
            if (deliver && head.invalid && inv_count != '1)
                inv_count <= inv_count + CNT_W'(1);
            case (count)
                2'd0: if (accept) head <= res;
                2'd1: begin
                    if (accept && deliver) head <= res;
                    else if (accept) spare <= res;
                end
                default: if (deliver) head <= spare;
            endcase
            count      <= count_nx;
            held_valid <= (count_nx != 2'd0);
            ready      <= (count_nx != 2'd2);
        end
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = held_valid;
    assign bus.sign_out     = head.sign;
    assign bus.exp_out      = head.exp;
    assign bus.mant_out     = head.mant;
    assign bus.is_nan       = head.is_nan;
    assign bus.is_snan      = head.is_snan;
    assign bus.is_pinf      = head.is_pinf;
    assign bus.is_ninf      = head.is_ninf;
    assign bus.is_zero      = head.is_zero;
    assign bus.is_subnormal = head.is_subnormal;
    assign bus.is_normal    = head.is_normal;
    assign bus.bypass       = head.bypass;
    assign bus.invalid      = head.invalid;
    assign invalid_cnt      = inv_count;
endmodule

// File: tb/tb_fp_special_classify_pipe.sv
// Bench for fp_special_classify_pipe: FTZ=0/CNT_W=8 and FTZ=1/CNT_W=2
// instances share stimulus; a queue of accepted operands feeds a model.
module tb_fp_special_classify_pipe;
    localparam int EW = 5;
    localparam int MW = 10;
    localparam int RW = 1 + EW + MW + 9;

    typedef struct packed {
        logic        sq;
        logic [15:0] w;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [RW-1:0] o0, o1;

    always #5 clk = ~clk;

    fp_special_classify_pipe_if #(.EXP_W(EW), .MAN_W(MW)) b0 ();
    fp_special_classify_pipe_if #(.EXP_W(EW), .MAN_W(MW)) b1 ();

    assign b1.in_valid  = b0.in_valid;
    assign b1.mode_sqrt = b0.mode_sqrt;
    assign b1.sign_in   = b0.sign_in;
    assign b1.exp_in    = b0.exp_in;
    assign b1.mant_in   = b0.mant_in;
    assign b1.out_ready = b0.out_ready;

    fp_special_classify_pipe #(.EXP_W(EW), .MAN_W(MW), .FTZ(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(b0), .invalid_cnt(cnt0)
    );
    fp_special_classify_pipe #(.EXP_W(EW), .MAN_W(MW), .FTZ(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(b1), .invalid_cnt(cnt1)
    );

    assign o0 = {b0.sign_out, b0.exp_out, b0.mant_out, b0.is_nan, b0.is_snan,
                 b0.is_pinf, b0.is_ninf, b0.is_zero, b0.is_subnormal,
                 b0.is_normal, b0.bypass, b0.invalid};
    assign o1 = {b1.sign_out, b1.exp_out, b1.mant_out, b1.is_nan, b1.is_snan,
                 b1.is_pinf, b1.is_ninf, b1.is_zero, b1.is_subnormal,
                 b1.is_normal, b1.bypass, b1.invalid};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: IEEE special-case rules on a 16-bit half-precision word
    function automatic logic [RW-1:0] ref_out(input bit ftz, input bit sq, input logic [15:0] w);
        int e, m, emax, q, ne, nm;
        bit s, ns, inv, zero, byp;
        bit [6:0] cls;
        s = w[15];
        e = int'(w[14:10]);
        m = int'(w[9:0]);
        emax = (1 << EW) - 1;
        q = 1 << (MW - 1);
        ns = s; ne = e; nm = m; inv = 0; cls = '0;
        if (e == emax && m != 0) begin
            nm = m | q;
            cls[6] = 1;
            if (m < q) begin cls[5] = 1; inv = 1; end
        end else begin
            zero = (e == 0) && (m == 0 || ftz);
            if (sq && s && !zero) begin
                ns = 1; ne = emax; nm = q; cls[6] = 1; inv = 1;
            end else if (e == emax) begin
                if (s) cls[3] = 1; else cls[4] = 1;
            end else if (zero) begin
                ne = 0; nm = 0; cls[2] = 1;
            end else if (e == 0) begin
                cls[1] = 1;
            end else begin
                cls[0] = 1;
            end
        end
        byp = cls[6] | cls[4] | cls[3] | cls[2];
        return {ns, ne[EW-1:0], nm[MW-1:0], cls, byp, inv};
    endfunction

    op_t q[$];
    int  m0 = 0;
    int  m1 = 0;
    bit  exp_rdy = 0;

    // Cycle monitor: checks outputs and tracks handshakes at the next edge
    always @(negedge clk) begin
        op_t f;
        if (!rst_n) begin
            q.delete();
            m0 = 0; m1 = 0; exp_rdy = 0;
            check("rst_vld0", b0.out_valid, 0);
            check("rst_vld1", b1.out_valid, 0);
            check("rst_rdy", b0.in_ready, 0);
        end else begin
            check("rdy0", b0.in_ready, exp_rdy);
            check("rdy1", b1.in_ready, exp_rdy);
            check("vld0", b0.out_valid, q.size() != 0);
            check("vld1", b1.out_valid, q.size() != 0);
            check("cnt0", cnt0, m0);
            check("cnt1", cnt1, m1);
            if (q.size() != 0) begin
                f = q[0];
                check("data0", o0, ref_out(0, f.sq, f.w));
                check("data1", o1, ref_out(1, f.sq, f.w));
            end
            if (enable) begin
                if (q.size() != 0 && b0.out_ready) begin
                    f = q.pop_front();
                    if (ref_out(0, f.sq, f.w) & 1 && m0 < 255) m0++;
                    if (ref_out(1, f.sq, f.w) & 1 && m1 < 3) m1++;
                end
                if (b0.in_valid && exp_rdy)
                    q.push_back({b0.mode_sqrt, b0.sign_in, b0.exp_in, b0.mant_in});
                exp_rdy = (q.size() < 2);
            end else begin
                q.delete();
                exp_rdy = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic sq, input logic [15:0] w);
        int t = 0;
        bit acc;
        b0.in_valid = 1'b1;
        b0.mode_sqrt = sq;
        {b0.sign_in, b0.exp_in, b0.mant_in} = w;
        do begin
            @(negedge clk);
            acc = b0.in_ready && enable;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 0, 1);
        b0.in_valid = 1'b0;
    endtask

    initial begin
        int snap;
        logic [15:0] w;
        b0.in_valid = 0; b0.mode_sqrt = 1; b0.sign_in = 0;
        b0.exp_in = 0; b0.mant_in = 0; b0.out_ready = 1;
        enable = 1;
        idle(2);
        rst_n = 1;
        idle(1);

        send(1, 16'h3C00); send(1, 16'hBC00);
        send(1, 16'h7C01); send(1, 16'h8000);
        idle(3);
        check("cnt_plan", cnt0, 2);

        send(0, 16'hFC00); send(1, 16'hFC00);
        send(1, 16'h0001); send(0, 16'h0001);
        idle(3);

        b0.out_ready = 0;
        fork
            begin send(0, 16'h3555); send(0, 16'h7D00); send(0, 16'h0200); end
            begin idle(6); b0.out_ready = 1; end
        join
        idle(4);

        b0.out_ready = 0;
        snap = m0;
        send(1, 16'hBC00); send(1, 16'h7C01);
        idle(1);
        enable = 0;
        idle(1);
        enable = 1;
        idle(2);
        b0.out_ready = 1;
        idle(3);
        check("cnt_hold", cnt0, snap);

        rst_n = 0; idle(1); rst_n = 1; idle(1);
        repeat (5) send(0, 16'h7C01);
        idle(3);
        check("sat1", cnt1, 3);
        check("sat0", cnt0, 5);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(posedge clk);
                #2 rst_n = 0;
                #1;
                check("arst0", {o0, b0.out_valid, b0.in_ready, cnt0}, 0);
                check("arst1", {o1, b1.out_valid, b1.in_ready, cnt1}, 0);
                idle(2);
                rst_n = 1;
            end
            w[15] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: w[14:10] = 5'd0;
                1: w[14:10] = 5'd31;
                default: w[14:10] = 5'($urandom_range(1, 30));
            endcase
            w[9:0] = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom);
            b0.in_valid = ($urandom_range(0, 9) < 7);
            b0.mode_sqrt = 1'($urandom_range(0, 1));
            {b0.sign_in, b0.exp_in, b0.mant_in} = w;
            b0.out_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 39) != 0);
            idle(1);
        end

        b0.in_valid = 0;
        b0.out_ready = 1;
        enable = 1;
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
